// File: rtl/spi_cache_pkg.sv
// Shared types and helpers for the SPI memory read cache.
// Holds the FSM state encoding, address split helpers and counter limit.
package spi_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        WAIT_DN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Line index: the low idx_w address bits.
    function automatic logic [31:0] idx_of(
        input logic [31:0] addr,
        input int          idx_w
    );
        return addr & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: everything above the index bits.
    function automatic logic [31:0] tag_of(
        input logic [31:0] addr,
        input int          idx_w
    );
        return addr >> idx_w;
    endfunction

endpackage

// File: rtl/spi_cache_store.sv
// Valid/tag/data arrays of the direct-mapped cache.
// Ports: async read (rd_*), fill write (fill_*), 3-way invalidate (inv_*), flush.
module spi_cache_store
    import spi_cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int TAG_W  = 12,
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_en,
    input  logic [IDX_W-1:0]  inv_idx_a,
    input  logic [IDX_W-1:0]  inv_idx_b,
    input  logic [IDX_W-1:0]  inv_idx_c
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Flush overrides a same-edge fill so the entry stays invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (fill_en)
                valid[fill_idx] <= 1'b1;
            if (inv_en) begin
                valid[inv_idx_a] <= 1'b0;
                valid[inv_idx_b] <= 1'b0;
                valid[inv_idx_c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/spi_mem_cache.sv
// Direct-mapped write-through read cache in front of the SPI memory controller.
// Ports: up_* hub side, dn_* controller side, flush, hit/miss counters, busy.
module spi_mem_cache
    import spi_cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              up_req,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [DATA_W-1:0] up_wdata,
    input  logic              up_cs_select,
    output logic [DATA_W-1:0] up_rdata,
    output logic              up_ready,
    output logic              dn_req,
    output logic              dn_we,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_wdata,
    output logic              dn_cs_select,
    input  logic [DATA_W-1:0] dn_rdata,
    input  logic              dn_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic              busy
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_t state, next_state;

    logic              a_we;
    logic              a_cs;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;

    logic [31:0]       idx_w32;
    logic [31:0]       tag_w32;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic              unused_hi;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              cacheable_rd;
    logic              hit;
    logic              dn_done;
    logic              fill_en;
    logic              inv_en;

    always_comb begin
        idx_w32 = idx_of(32'(a_addr), IDX_W);
        tag_w32 = tag_of(32'(a_addr), IDX_W);
    end

    assign a_idx     = idx_w32[IDX_W-1:0];
    assign a_tag     = tag_w32[TAG_W-1:0];
    assign unused_hi = ^{idx_w32[31:IDX_W], tag_w32[31:TAG_W]};

    assign cacheable_rd = !a_we && !a_cs;
    assign hit = cacheable_rd && rd_valid && (rd_tag == a_tag);
    assign dn_done = (state == WAIT_DN) && dn_ready;
    assign fill_en = dn_done && cacheable_rd;
    // A RAM write touches bytes A and A+1, held by entries A-1, A and A+1.
    assign inv_en  = dn_done && a_we && !a_cs;

    spi_cache_store #(
        .LINES  (LINES),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .rd_idx    (a_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .fill_en   (fill_en),
        .fill_idx  (a_idx),
        .fill_tag  (a_tag),
        .fill_data (dn_rdata),
        .inv_en    (inv_en),
        .inv_idx_a (a_idx - IDX_W'(1)),
        .inv_idx_b (a_idx),
        .inv_idx_c (a_idx + IDX_W'(1))
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (up_req)   next_state = LOOKUP;
            LOOKUP:  next_state = hit ? RELEASE : WAIT_DN;
            WAIT_DN: if (dn_ready) next_state = RELEASE;
            RELEASE: if (!up_req)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_we         <= 1'b0;
            a_cs         <= 1'b0;
            a_addr       <= '0;
            a_wdata      <= '0;
            up_rdata     <= '0;
            up_ready     <= 1'b0;
            dn_req       <= 1'b0;
            dn_we        <= 1'b0;
            dn_addr      <= '0;
            dn_wdata     <= '0;
            dn_cs_select <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            busy         <= 1'b0;
        end else begin
            up_ready <= 1'b0;
            busy     <= (next_state != IDLE);
            unique case (state)
                IDLE: begin
                    if (up_req) begin
                        a_we    <= up_we;
                        a_cs    <= up_cs_select;
                        a_addr  <= up_addr;
                        a_wdata <= up_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        up_ready <= 1'b1;
                        up_rdata <= rd_data;
                        if (hit_cnt != CNT_MAX)
                            hit_cnt <= hit_cnt + 16'd1;
                    end else begin
                        dn_req       <= 1'b1;
                        dn_we        <= a_we;
                        dn_addr      <= a_addr;
                        dn_wdata     <= a_wdata;
                        dn_cs_select <= a_cs;
                        if (cacheable_rd && miss_cnt != CNT_MAX)
                            miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                WAIT_DN: begin
                    if (dn_ready) begin
                        dn_req   <= 1'b0;
                        up_ready <= 1'b1;
                        up_rdata <= a_we ? '0 : dn_rdata;
                    end
                end
                RELEASE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_cache.sv
// Directed self-checking bench for spi_mem_cache.
// Byte-array SPI memory model answers dn_* requests after a fixed delay.
module tb_spi_mem_cache;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        up_req;
    logic        up_we;
    logic [15:0] up_addr;
    logic [15:0] up_wdata;
    logic        up_cs_select;
    logic [15:0] up_rdata;
    logic        up_ready;
    logic        dn_req;
    logic        dn_we;
    logic [15:0] dn_addr;
    logic [15:0] dn_wdata;
    logic        dn_cs_select;
    logic [15:0] dn_rdata;
    logic        dn_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:65535];
    int          n_dn = 0;
    int          wcnt;
    logic        last_we;
    logic        last_cs;
    logic [15:0] last_addr;
    logic        stall = 1'b0;
    logic        flush_race = 1'b0;

    spi_mem_cache dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .up_req       (up_req),
        .up_we        (up_we),
        .up_addr      (up_addr),
        .up_wdata     (up_wdata),
        .up_cs_select (up_cs_select),
        .up_rdata     (up_rdata),
        .up_ready     (up_ready),
        .dn_req       (dn_req),
        .dn_we        (dn_we),
        .dn_addr      (dn_addr),
        .dn_wdata     (dn_wdata),
        .dn_cs_select (dn_cs_select),
        .dn_rdata     (dn_rdata),
        .dn_ready     (dn_ready),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream model: answers two negedges after dn_req is first seen.
    initial begin
        dn_ready = 1'b0;
        dn_rdata = '0;
        flush    = 1'b0;
        wcnt     = 0;
        forever begin
            @(negedge clk);
            dn_ready = 1'b0;
            flush    = 1'b0;
            if (dn_req && !stall && reset_n) begin
                if (wcnt == 2) begin
                    wcnt      = 0;
                    dn_ready  = 1'b1;
                    n_dn++;
                    last_we   = dn_we;
                    last_cs   = dn_cs_select;
                    last_addr = dn_addr;
                    if (flush_race)
                        flush = 1'b1;
                    if (dn_we) begin
                        mem[dn_addr]         = dn_wdata[7:0];
                        mem[dn_addr + 16'd1] = dn_wdata[15:8];
                        dn_rdata             = 16'h5555;
                    end else if (dn_cs_select) begin
                        dn_rdata = dn_addr ^ 16'hA5A5;
                    end else begin
                        dn_rdata = {mem[dn_addr + 16'd1], mem[dn_addr]};
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic access(
        input  logic        we,
        input  logic [15:0] addr,
        input  logic [15:0] wd,
        input  logic        cs,
        output logic [15:0] rd,
        output int          lat
    );
        @(negedge clk);
        up_we        = we;
        up_addr      = addr;
        up_wdata     = wd;
        up_cs_select = cs;
        up_req       = 1'b1;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (up_ready) break;
        end
        total++;
        if (up_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout addr=%h got up_ready=%b exp 1", addr, up_ready);
        end
        rd = up_rdata;
        @(negedge clk);
        up_req = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({up_ready, dn_req, busy, up_rdata} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outs got %b%b%b %h exp 000 0000",
                     up_ready, dn_req, busy, up_rdata);
        end
        total++;
        if ({hit_cnt, miss_cnt} !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got %h/%h exp 0/0", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_miss_hit();
        logic [15:0] rd;
        int          lat;
        int          n0;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        n0 = n_dn;
        access(1'b0, 16'h0100, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h1234 || n_dn - n0 !== 1 || lat !== 5) begin
            bad++;
            $display("FAIL miss1 got rd=%h n=%0d lat=%0d exp 1234 1 5",
                     rd, n_dn - n0, lat);
        end
        access(1'b0, 16'h0100, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h1234 || n_dn - n0 !== 1 || lat !== 2) begin
            bad++;
            $display("FAIL hit1 got rd=%h n=%0d lat=%0d exp 1234 1 2",
                     rd, n_dn - n0, lat);
        end
        total++;
        if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            bad++;
            $display("FAIL cnt_mh got %0d/%0d exp 1/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_write_inv();
        logic [15:0] rd;
        int          lat;
        int          n0;
        mem[16'h00FF] = 8'hAA;
        mem[16'h0102] = 8'h56;
        access(1'b0, 16'h00FF, 16'h0, 1'b0, rd, lat);
        access(1'b0, 16'h0100, 16'h0, 1'b0, rd, lat);
        access(1'b0, 16'h0101, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h5612) begin
            bad++;
            $display("FAIL fill101 got %h exp 5612", rd);
        end
        n0 = n_dn;
        access(1'b1, 16'h0100, 16'hBEEF, 1'b0, rd, lat);
        total++;
        if (n_dn - n0 !== 1 || last_we !== 1'b1 ||
            last_addr !== 16'h0100 || rd !== 16'h0000) begin
            bad++;
            $display("FAIL wr_fwd got n=%0d we=%b a=%h rd=%h exp 1 1 0100 0000",
                     n_dn - n0, last_we, last_addr, rd);
        end
        n0 = n_dn;
        access(1'b0, 16'h00FF, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'hEFAA || n_dn - n0 !== 1) begin
            bad++;
            $display("FAIL inv_0ff got rd=%h n=%0d exp EFAA 1", rd, n_dn - n0);
        end
        access(1'b0, 16'h0100, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'hBEEF || n_dn - n0 !== 2) begin
            bad++;
            $display("FAIL inv_100 got rd=%h n=%0d exp BEEF 2", rd, n_dn - n0);
        end
        access(1'b0, 16'h0101, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h56BE || n_dn - n0 !== 3) begin
            bad++;
            $display("FAIL inv_101 got rd=%h n=%0d exp 56BE 3", rd, n_dn - n0);
        end
        total++;
        if (hit_cnt !== 16'd2 || miss_cnt !== 16'd6) begin
            bad++;
            $display("FAIL cnt_wi got %0d/%0d exp 2/6", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] rd;
        int          lat;
        int          n0;
        apply_reset();
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0020] = 8'h33;
        mem[16'h0021] = 8'h44;
        n0 = n_dn;
        access(1'b0, 16'h0010, 16'h0, 1'b0, rd, lat);
        access(1'b0, 16'h0020, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h4433) begin
            bad++;
            $display("FAIL conf20 got %h exp 4433", rd);
        end
        access(1'b0, 16'h0010, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h2211 || n_dn - n0 !== 3) begin
            bad++;
            $display("FAIL conf10 got rd=%h n=%0d exp 2211 3", rd, n_dn - n0);
        end
        total++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd3) begin
            bad++;
            $display("FAIL cnt_cf got %0d/%0d exp 0/3", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] rd;
        int          lat;
        int          n0;
        n0 = n_dn;
        access(1'b0, 16'h0200, 16'h0, 1'b1, rd, lat);
        access(1'b0, 16'h0200, 16'h0, 1'b1, rd, lat);
        total++;
        if (rd !== 16'hA7A5 || n_dn - n0 !== 2 || last_cs !== 1'b1) begin
            bad++;
            $display("FAIL bypass got rd=%h n=%0d cs=%b exp A7A5 2 1",
                     rd, n_dn - n0, last_cs);
        end
        total++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd3) begin
            bad++;
            $display("FAIL cnt_bp got %0d/%0d exp 0/3", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_flush_race();
        logic [15:0] rd;
        int          lat;
        int          n0;
        mem[16'h0300] = 8'h78;
        mem[16'h0301] = 8'h9A;
        n0 = n_dn;
        flush_race = 1'b1;
        access(1'b0, 16'h0300, 16'h0, 1'b0, rd, lat);
        flush_race = 1'b0;
        access(1'b0, 16'h0300, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h9A78 || n_dn - n0 !== 2) begin
            bad++;
            $display("FAIL flush_race got rd=%h n=%0d exp 9A78 2", rd, n_dn - n0);
        end
        access(1'b0, 16'h0300, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'h9A78 || n_dn - n0 !== 2 || lat !== 2) begin
            bad++;
            $display("FAIL refill got rd=%h n=%0d lat=%0d exp 9A78 2 2",
                     rd, n_dn - n0, lat);
        end
        total++;
        if (hit_cnt !== 16'd1 || miss_cnt !== 16'd5) begin
            bad++;
            $display("FAIL cnt_fr got %0d/%0d exp 1/5", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int pulses;
        int k;
        n0 = n_dn;
        @(negedge clk);
        up_we        = 1'b0;
        up_addr      = 16'h0300;
        up_cs_select = 1'b0;
        up_req       = 1'b1;
        k = 0;
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (up_ready) break;
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (up_ready) pulses++;
        end
        total++;
        if (pulses !== 0 || n_dn - n0 !== 0 || k !== 2) begin
            bad++;
            $display("FAIL held_req got pulses=%0d n=%0d k=%0d exp 0 0 2",
                     pulses, n_dn - n0, k);
        end
        @(negedge clk);
        up_req = 1'b0;
        total++;
        if (hit_cnt !== 16'd2 || miss_cnt !== 16'd5) begin
            bad++;
            $display("FAIL cnt_held got %0d/%0d exp 2/5", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int          lat;
        int          k;
        int          n0;
        stall = 1'b1;
        @(negedge clk);
        up_we        = 1'b0;
        up_addr      = 16'h0100;
        up_cs_select = 1'b0;
        up_req       = 1'b1;
        k = 0;
        while (k < 20 && !dn_req) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (dn_req !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait got dn_req=%b busy=%b exp 1 1", dn_req, busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({dn_req, busy, up_ready} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset got %b%b%b exp 000", dn_req, busy, up_ready);
        end
        up_req = 1'b0;
        stall  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n0 = n_dn;
        access(1'b0, 16'h0100, 16'h0, 1'b0, rd, lat);
        total++;
        if (rd !== 16'hBEEF || n_dn - n0 !== 1 || miss_cnt !== 16'd1 ||
            hit_cnt !== 16'd0) begin
            bad++;
            $display("FAIL post_reset got rd=%h n=%0d cnt=%0d/%0d exp BEEF 1 0/1",
                     rd, n_dn - n0, hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        up_req       = 1'b0;
        up_we        = 1'b0;
        up_addr      = '0;
        up_wdata     = '0;
        up_cs_select = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_miss_hit();
        test_write_inv();
        test_conflict();
        test_bypass();
        test_flush_race();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mem_cache.md
Name: spi_mem_cache

Overview:
- Small direct-mapped, write-through, no-write-allocate read cache between interconnect_hub's SPI-memory port and spi_memory_controller.
- Removes repeated serial SPI SRAM transactions for CPU fetches and loads.
- Only RAM accesses (cs_select=0) are cached; flash accesses (cs_select=1) pass through uncached.
- Single outstanding transaction; level-req / pulse-ready handshake on both sides.

Parameters:
- LINES, 16, number of cache entries (power of 2, ≥4); IDX_W = clog2(LINES).
- ADDR_W, 16, byte address width.
- DATA_W, 16, data width per entry.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- flush  in  1  one-cycle pulse; invalidates all entries.
- up_req  in  1  hub request, held until up_ready.
- up_we  in  1  1=write, 0=read.
- up_addr  in  ADDR_W  byte address.
- up_wdata  in  DATA_W  write data.
- up_cs_select  in  1  0=RAM (cacheable), 1=flash (bypass).
- up_rdata  out  DATA_W  read data, valid with up_ready.
- up_ready  out  1  one-cycle completion pulse.
- dn_req  out  1  request to spi_memory_controller.
- dn_we  out  1  forwarded write enable.
- dn_addr  out  ADDR_W  forwarded address.
- dn_wdata  out  DATA_W  forwarded write data.
- dn_cs_select  out  1  forwarded cs_select.
- dn_rdata  in  DATA_W  controller read data.
- dn_ready  in  1  controller completion pulse.
- hit_cnt  out  16  saturating count of cacheable read hits.
- miss_cnt  out  16  saturating count of cacheable read misses.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; all valid bits 0; state IDLE. Tag and data arrays are not reset.
- Entry layout: {valid, tag = addr[ADDR_W-1:IDX_W], data}; index = addr[IDX_W-1:0]. Data is the 16-bit word read at byte address A = {mem[A+1], mem[A]}.
- FSM states: IDLE, LOOKUP, WAIT_DN, RELEASE.
- IDLE:
  - On up_req=1, capture addr/we/wdata/cs_select and go to LOOKUP.
- LOOKUP:
  - Hit = read AND cs_select=0 AND valid[index] AND tag match.
  - On hit: next cycle up_ready=1, up_rdata=entry data, hit_cnt+1; go to RELEASE.
  - Otherwise: drive dn_* from captured values, dn_req=1; go to WAIT_DN.
  - Cacheable read miss: miss_cnt+1.
- WAIT_DN:
  - Hold dn_req and dn_* stable until dn_ready=1.
  - In the dn_ready cycle, clear dn_req on the next edge.
  - Next cycle: up_ready=1, up_rdata=dn_rdata (0 for writes); go to RELEASE.
  - Cacheable read: fill entry (valid=1, tag, data=dn_rdata) on the dn_ready edge.
  - Write with cs_select=0: on the dn_ready edge, clear valid at indices (A-1), A, (A+1) mod LINES, unconditionally with no tag compare, because these entries contain bytes A and A+1.
- RELEASE: wait for up_req=0, then go to IDLE. A held up_req never starts a second transaction.
- Latency:
  - Hit: up_ready 2 cycles after the edge that samples up_req.
  - Miss: dn_req asserted 2 cycles after sampling; up_ready 1 cycle after dn_ready.
- flush: clears all valid bits on that edge in any state. If flush coincides with a fill, flush wins and the entry stays invalid. flush does not abort an in-flight transaction.
- Counters: saturate at 0xFFFF and clear only on reset. Bypass reads and all writes are not counted.
- dn_ready outside WAIT_DN is ignored.
- Reset mid-operation: asynchronously forces IDLE, dn_req=0, up_ready=0, all valid=0.

Decomposition:
- Shared package spi_cache_pkg holds:
  - state enum (IDLE, LOOKUP, WAIT_DN, RELEASE);
  - idx_of() and tag_of() helper functions;
  - counter-saturation constant 16'hFFFF.
- Sub-module spi_cache_store holds:
  - the valid/tag/data arrays;
  - 1 combinational read port and 1 fill port;
  - a 3-index invalidate port and a flush input.
- The FSM, counters and handshake logic stay in spi_mem_cache.

Test Plan:
- Miss then hit (LINES=16): SRAM[0x0100]=0x34, SRAM[0x0101]=0x12.
  - First read 0x0100 → exactly one dn_req, up_rdata=0x1234.
  - Re-read → no dn_req, up_ready 2 cycles after req, up_rdata=0x1234.
  - hit_cnt=1, miss_cnt=1.
- Write invalidation: cache 0x00FF, 0x0100 and 0x0101, then write 0xBEEF to 0x0100 → forwarded with dn_we=1.
  - Re-reading each of the three addresses misses.
  - Read 0x0100 returns 0xBEEF; read 0x00FF returns upper byte 0xEF.
- Conflict eviction: read 0x0010, 0x0020, 0x0010 (all index 0) → three downstream reads, miss_cnt=3, hit_cnt=0.
- Flash bypass: two reads of 0x0200 with up_cs_select=1 → two dn_req with dn_cs_select=1; counters unchanged.
- Flush race: assert flush in the same cycle as dn_ready of a fill for 0x0300 → next read of 0x0300 misses.
- Reset mid-miss: pull reset_n low during WAIT_DN → dn_req, busy, up_ready read 0 immediately. After release, a read of 0x0100 misses and returns correct data.
